// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder: two-stage pipeline, stage 1 transition-minimises each byte,
// stage 2 DC-balances it against a per-channel running disparity or emits a control token.
module dvi_tmds_encoder #(
    parameter bit SYNC_INV = 1'b0
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2
);

    localparam logic [9:0] TokCtl00 = 10'h354;
    localparam logic [9:0] TokCtl01 = 10'h0AB;
    localparam logic [9:0] TokCtl10 = 10'h154;
    localparam logic [9:0] TokCtl11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] tm_stage(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctl_token(input logic [1:0] c);
        logic [9:0] t;
        unique case (c)
            2'b00:   t = TokCtl00;
            2'b01:   t = TokCtl01;
            2'b10:   t = TokCtl10;
            default: t = TokCtl11;
        endcase
        return t;
    endfunction

    // Index 0 = blue (ch0), 1 = green (ch1), 2 = red (ch2).
    logic [2:0][7:0] pix;
    assign pix = {r, g, b};

    // Stage 1 state
    logic [2:0][8:0] q_m_d, q_m_q;
    logic            de_d, de_q;
    logic [1:0]      ctrl_d, ctrl_q;

    // Stage 2 state
    logic [2:0][9:0] sym_d, sym_q;
    logic [2:0][4:0] cnt_d, cnt_q;

    always_comb begin : stage1_comb
        logic hs;
        logic vs;
        hs     = hsync ^ SYNC_INV;
        vs     = vsync ^ SYNC_INV;
        q_m_d  = '0;
        for (int ch = 0; ch < 3; ch++) begin
            q_m_d[ch] = tm_stage(pix[ch]);
        end
        de_d   = de;
        ctrl_d = {vs, hs};
    end

    // Disparity arithmetic is 5-bit two's complement; diff = N1 - N0 = 2*N1 - 8.
    always_comb begin : stage2_comb
        logic [8:0] qm;
        logic [4:0] cnt;
        logic [3:0] n1;
        logic [4:0] diff;
        logic       cnt_pos;
        logic       cnt_neg;
        qm      = 9'd0;
        cnt     = 5'd0;
        n1      = 4'd0;
        diff    = 5'd0;
        cnt_pos = 1'b0;
        cnt_neg = 1'b0;
        sym_d   = '0;
        cnt_d   = '0;
        for (int ch = 0; ch < 3; ch++) begin
            qm      = q_m_q[ch];
            cnt     = cnt_q[ch];
            n1      = popcount8(qm[7:0]);
            diff    = {n1, 1'b0} - 5'd8;
            cnt_pos = !cnt[4] && (cnt != 5'd0);
            cnt_neg = cnt[4];
            if (!de_q) begin
                sym_d[ch] = (ch == 0) ? ctl_token(ctrl_q) : TokCtl00;
                cnt_d[ch] = 5'd0;
            end else if ((cnt == 5'd0) || (n1 == 4'd4)) begin
                sym_d[ch] = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                cnt_d[ch] = qm[8] ? (cnt + diff) : (cnt - diff);
            end else if ((cnt_pos && (n1 > 4'd4)) || (cnt_neg && (n1 < 4'd4))) begin
                sym_d[ch] = {1'b1, qm[8], ~qm[7:0]};
                cnt_d[ch] = cnt + {3'b000, qm[8], 1'b0} - diff;
            end else begin
                sym_d[ch] = {1'b0, qm[8], qm[7:0]};
                cnt_d[ch] = cnt + diff - {3'b000, ~qm[8], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            q_m_q  <= '0;
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            sym_q  <= {3{TokCtl00}};
            cnt_q  <= '0;
        end else begin
            q_m_q  <= q_m_d;
            de_q   <= de_d;
            ctrl_q <= ctrl_d;
            sym_q  <= sym_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds_ch0 = sym_q[0];
    assign tmds_ch1 = sym_q[1];
    assign tmds_ch2 = sym_q[2];

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Scoreboard bench for dvi_tmds_encoder: a driver pushes model-predicted symbols per edge,
// a negedge monitor pops and compares them, plus decodes active symbols back to bytes.
module tb_dvi_tmds_encoder;

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b1;
    logic       de = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] r = 8'd0;
    logic [7:0] g = 8'd0;
    logic [7:0] b = 8'd0;
    logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;
    logic [9:0] inv_ch0, inv_ch1, inv_ch2;

    always #5 clk_pix = ~clk_pix;

    dvi_tmds_encoder #(.SYNC_INV(1'b0)) dut (
        .clk_pix (clk_pix), .rst_pix (rst_pix), .de (de), .hsync (hsync), .vsync (vsync),
        .r (r), .g (g), .b (b),
        .tmds_ch0 (tmds_ch0), .tmds_ch1 (tmds_ch1), .tmds_ch2 (tmds_ch2)
    );

    dvi_tmds_encoder #(.SYNC_INV(1'b1)) dut_inv (
        .clk_pix (clk_pix), .rst_pix (rst_pix), .de (de), .hsync (hsync), .vsync (vsync),
        .r (r), .g (g), .b (b),
        .tmds_ch0 (inv_ch0), .tmds_ch1 (inv_ch1), .tmds_ch2 (inv_ch2)
    );

    typedef struct {
        logic [2:0][9:0] s;
        logic [9:0]      inv0;
        bit              act;
        logic [2:0][7:0] byt;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic [9:0] c0, c1, c2, ci;
    } want_t;

    exp_t  sb[$];
    want_t cq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_edge = 0;
    int    m_edge = 0;
    bit    done = 1'b0;

    // Reference model state: disparity per channel and the input seen at the previous edge.
    int              m_cnt[3] = '{0, 0, 0};
    bit              p_rst = 1'b1;
    bit              p_de = 1'b0;
    bit              p_hs = 1'b0;
    bit              p_vs = 1'b0;
    logic [2:0][7:0] p_pix = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %0h expected %0h", nm, m_edge, act, exp);
        end
    endtask

    function automatic logic [9:0] m_token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    // q_m[i] is the prefix parity of d[0..i]; the XNOR chain flips odd positions.
    task automatic m_encode(input logic [7:0] d, input int cin, output logic [9:0] sym,
                            output int cout);
        int         n1;
        bit         use_xnor;
        logic [8:0] qm;
        bit         par;
        int         bal;
        n1       = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        par      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            par   = par ^ d[i];
            qm[i] = par ^ (use_xnor && (i % 2 == 1));
        end
        qm[8] = !use_xnor;
        bal   = 2 * $countones(qm[7:0]) - 8;
        if (cin == 0 || bal == 0) begin
            sym  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cout = cin + (qm[8] ? bal : -bal);
        end else if ((cin > 0 && bal > 0) || (cin < 0 && bal < 0)) begin
            sym  = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + 2 * int'(qm[8]) - bal;
        end else begin
            sym  = {1'b0, qm[8], qm[7:0]};
            cout = cin + bal - (qm[8] ? 0 : 2);
        end
    endtask

    function automatic logic [7:0] m_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] o;
        d    = s[9] ? ~s[7:0] : s[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    task automatic want(input int off, input logic [3:0] mask, input logic [9:0] c0,
                        input logic [9:0] c1, input logic [9:0] c2, input logic [9:0] ci);
        want_t w;
        w.cyc  = n_edge + off;
        w.mask = mask;
        w.c0   = c0;
        w.c1   = c1;
        w.c2   = c2;
        w.ci   = ci;
        cq.push_back(w);
    endtask

    task automatic drive(input bit rst_i, input bit de_i, input bit hs_i, input bit vs_i,
                         input logic [7:0] r_i, input logic [7:0] g_i, input logic [7:0] b_i);
        exp_t       e;
        logic [9:0] s;
        int         c;
        rst_pix = rst_i;
        de      = de_i;
        hsync   = hs_i;
        vsync   = vs_i;
        r       = r_i;
        g       = g_i;
        b       = b_i;
        e.act   = 1'b0;
        e.byt   = '0;
        if (rst_i) begin
            e.s    = {3{10'h354}};
            e.inv0 = 10'h354;
            m_cnt  = '{0, 0, 0};
        end else if (p_rst || !p_de) begin
            e.s[0] = p_rst ? 10'h354 : m_token({p_vs, p_hs});
            e.s[1] = 10'h354;
            e.s[2] = 10'h354;
            e.inv0 = p_rst ? 10'h354 : m_token({~p_vs, ~p_hs});
            m_cnt  = '{0, 0, 0};
        end else begin
            e.act = 1'b1;
            for (int ch = 0; ch < 3; ch++) begin
                m_encode(p_pix[ch], m_cnt[ch], s, c);
                e.s[ch]   = s;
                m_cnt[ch] = c;
                e.byt[ch] = p_pix[ch];
                chk("disparity_bound", 32'(c <= 10 && c >= -10), 32'd1);
            end
            e.inv0 = e.s[0];
        end
        sb.push_back(e);
        p_rst = rst_i;
        p_de  = de_i;
        p_hs  = hs_i;
        p_vs  = vs_i;
        p_pix = {r_i, g_i, b_i};
        @(posedge clk_pix);
        #1;
        n_edge++;
    endtask

    exp_t  mon_e;
    want_t mon_w;

    always @(negedge clk_pix) begin
        if (!done) begin
            if (sb.size() == 0) begin
                chk("scoreboard_entry", 32'd0, 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("ch0", tmds_ch0, mon_e.s[0]);
                chk("ch1", tmds_ch1, mon_e.s[1]);
                chk("ch2", tmds_ch2, mon_e.s[2]);
                chk("inv_ch0", inv_ch0, mon_e.inv0);
                chk("inv_ch1", inv_ch1, mon_e.s[1]);
                chk("inv_ch2", inv_ch2, mon_e.s[2]);
                if (mon_e.act) begin
                    chk("decode_b", m_decode(tmds_ch0), mon_e.byt[0]);
                    chk("decode_g", m_decode(tmds_ch1), mon_e.byt[1]);
                    chk("decode_r", m_decode(tmds_ch2), mon_e.byt[2]);
                end
            end
            while (cq.size() > 0 && cq[0].cyc <= m_edge) begin
                mon_w = cq.pop_front();
                chk("directed_cycle", mon_w.cyc, m_edge);
                if (mon_w.mask[0]) chk("directed_ch0", tmds_ch0, mon_w.c0);
                if (mon_w.mask[1]) chk("directed_ch1", tmds_ch1, mon_w.c1);
                if (mon_w.mask[2]) chk("directed_ch2", tmds_ch2, mon_w.c2);
                if (mon_w.mask[3]) chk("directed_inv_ch0", inv_ch0, mon_w.ci);
            end
            m_edge++;
        end
    end

    logic [9:0] tok_exp[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] alt_exp[4] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};

    initial begin
        int run;
        bit cde;
        int rleft;
        // Reset held three cycles with random inputs.
        repeat (3) begin
            want(0, 4'hF, 10'h354, 10'h354, 10'h354, 10'h354);
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        // Control tokens for each {vsync,hsync}; the inverted instance sees the complement.
        for (int c = 0; c < 4; c++) begin
            want(1, 4'hF, tok_exp[c], 10'h354, 10'h354, tok_exp[3-c]);
            drive(1'b0, 1'b0, c[0], c[1], 8'($urandom), 8'($urandom), 8'($urandom));
        end
        // Blue zero alternates disparity; green 0xFF takes the XNOR path.
        for (int k = 0; k < 4; k++) begin
            want(1, (k == 0) ? 4'b0011 : 4'b0001, alt_exp[k], 10'h200, 10'h0, 10'h0);
            drive(1'b0, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'hFF, 8'h00);
        end
        want(1, 4'b0111, 10'h354, 10'h354, 10'h354, 10'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h5A);
        // Same byte on all channels across a de rise: all change together.
        want(1, 4'b0111, 10'h263, 10'h263, 10'h263, 10'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h5A);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h5A, 8'h5A);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h5A);
        // Random sweep: de runs, random sync, occasional short resets.
        run   = 0;
        cde   = 1'b0;
        rleft = 0;
        for (int i = 0; i < 10000; i++) begin
            if (run == 0) begin
                cde = ~cde;
                run = $urandom_range(40, 1);
            end
            run--;
            if (rleft == 0 && $urandom_range(299, 0) == 0) rleft = $urandom_range(3, 1);
            drive(rleft != 0, cde, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom));
            if (rleft != 0) rleft--;
        end
        @(negedge clk_pix);
        #1;
        done = 1'b1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        chk("directed_drained", cq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
